// File: rtl/scalar_writeback_queue.sv
// Purpose : merges ALU results and load returns onto the scalar register file write port.
// Latency : 1 cycle from acceptance to WA3/WD3/WE3; a queued load issues 1 cycle after its first ALU-free cycle at the head.
// Backpr. : ALU has no back-pressure; loads are refused via mem_ready when the FIFO holds DEPTH entries.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-low reset
//   alu_valid/addr/data    ALU result stream, always wins the write port
//   mem_valid/addr/data    load return stream, mem_ready accepts it
//   WA3/WD3/WE3            register file write port (registered)
//   pending                one-hot OR of destinations of valid queued loads
//   count                  FIFO slot occupancy (includes invalidated entries)
//   drop_cnt               saturating count of illegal writes dropped
// Optional feature: define WB_DROP_COUNT_EN to build the dropped-write counter;
// otherwise drop_cnt is tied to zero.
module scalar_writeback_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_addr,
  input  logic [N-1:0]               alu_data,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_addr,
  input  logic [N-1:0]               mem_data,
  output logic                       mem_ready,
  output logic [4:0]                 WA3,
  output logic [N-1:0]               WD3,
  output logic                       WE3,
  output logic [15:0]                pending,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                drop_cnt
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // r0 is hard zero and r15 is the pc; neither is writable from writeback.
  function automatic logic is_legal(input logic [4:0] a);
    return !a[4] && (a[3:0] != 4'h0) && (a[3:0] != 4'hF);
  endfunction

  logic [4:0]       q_addr [DEPTH];
  logic [N-1:0]     q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt_q;

  logic alu_ok;
  logic mem_acc;
  logic mem_ok;
  logic head_busy;
  logic do_pop;
  logic do_byp;
  logic do_push;

  // Readiness uses the registered count only, so a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign mem_ready = rst && (cnt_q < DEPTH_C);

  assign alu_ok    = alu_valid && is_legal(alu_addr);
  assign mem_acc   = mem_valid && mem_ready;
  assign mem_ok    = mem_acc && is_legal(mem_addr);
  assign head_busy = (cnt_q != '0);
  assign do_pop    = !alu_ok && head_busy;
  assign do_byp    = !alu_ok && !head_busy && mem_ok;
  // A same-cycle ALU write to the same register makes the incoming load stale,
  // so it never takes a slot.
  assign do_push   = mem_ok && !do_byp && !(alu_ok && (alu_addr == mem_addr));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      q_vld  <= '0;
      WE3    <= 1'b0;
      WA3    <= '0;
      WD3    <= '0;
    end else begin
      // WAW: the ALU result is younger than every queued load.
      if (alu_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_addr[i] == alu_addr) q_vld[i] <= 1'b0;
        end
      end
      if (do_pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (do_push) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (alu_ok) begin
        WE3 <= 1'b1;
        WA3 <= alu_addr;
        WD3 <= alu_data;
      end else if (do_pop) begin
        // An invalidated head still frees its slot but writes nothing.
        WE3 <= q_vld[rd_ptr];
        if (q_vld[rd_ptr]) begin
          WA3 <= q_addr[rd_ptr];
          WD3 <= q_data[rd_ptr];
        end
      end else if (do_byp) begin
        WE3 <= 1'b1;
        WA3 <= mem_addr;
        WD3 <= mem_data;
      end else begin
        WE3 <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; q_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_addr[wr_ptr] <= mem_addr;
      q_data[wr_ptr] <= mem_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) pending[q_addr[i][3:0]] = 1'b1;
    end
  end

  assign count = cnt_q;

`ifdef WB_DROP_COUNT_EN
  logic        alu_ill;
  logic        mem_ill;
  logic [16:0] drop_sum;
  logic [15:0] drop_q;

  // Only loads actually handshaken count as dropped writes.
  assign alu_ill  = alu_valid && !is_legal(alu_addr);
  assign mem_ill  = mem_acc && !is_legal(mem_addr);
  assign drop_sum = {1'b0, drop_q} + 17'(alu_ill) + 17'(mem_ill);

  always_ff @(posedge clk) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_scalar_writeback_queue.sv
module tb_scalar_writeback_queue;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_addr = '0;
  logic [N-1:0]  alu_data = '0;
  logic          mem_valid = 1'b0;
  logic [4:0]    mem_addr = '0;
  logic [N-1:0]  mem_data = '0;
  logic          mem_ready;
  logic [4:0]    WA3;
  logic [N-1:0]  WD3;
  logic          WE3;
  logic [15:0]   pending;
  logic [2:0]    count;
  logic [15:0]   drop_cnt;

  scalar_writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .WA3(WA3), .WD3(WD3), .WE3(WE3),
    .pending(pending), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        v;
  } ent_t;

  ent_t        mq[$];     // model of the load FIFO, invalidated entries kept
  ent_t        exp_q[$];  // scoreboard of expected register file writes
  int unsigned m_drop = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [4:0] a);
    return (a[4] == 1'b0) && (a[3:0] != 4'h0) && (a[3:0] != 4'hF);
  endfunction

  function automatic logic [15:0] m_pending();
    logic [15:0] p;
    p = '0;
    foreach (mq[i]) if (mq[i].v) p[mq[i].a[3:0]] = 1'b1;
    return p;
  endfunction

  function automatic logic [15:0] exp_drop();
`ifdef WB_DROP_COUNT_EN
    return (m_drop > 32'hFFFF) ? 16'hFFFF : 16'(m_drop);
`else
    return 16'h0;
`endif
  endfunction

  // Every observed write must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (mon_en && WE3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we3", 64'(WE3), 64'd0);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("wa3", 64'(WA3), 64'(e.a));
        chk("wd3", 64'(WD3), 64'(e.d));
      end
    end
  end

  // One cycle of stimulus; the model predicts the write and the FIFO state.
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bit   rdy, alu_ok, macc, byp;
    ent_t e;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    rdy = (mq.size() < DEPTH);
    chk("mem_ready", 64'(mem_ready), 64'(rdy));
    alu_ok = av && legal(aa);
    macc   = mv && rdy && legal(ma);
    byp    = 1'b0;
    if (av && !legal(aa)) m_drop++;
    if (mv && rdy && !legal(ma)) m_drop++;
    if (alu_ok) begin
      exp_q.push_back('{aa, ad, 1'b1});
      foreach (mq[i]) if (mq[i].a == aa) mq[i].v = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.v) exp_q.push_back(e);
    end else if (macc) begin
      exp_q.push_back('{ma, md, 1'b1});
      byp = 1'b1;
    end
    if (macc && !byp && !(alu_ok && aa == ma)) mq.push_back('{ma, md, 1'b1});
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    chk("count", 64'(count), 64'(mq.size()));
    chk("pending", 64'(pending), 64'(m_pending()));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop()));
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
    mq.delete();
    m_drop = 0;
    chk("rst_we3", 64'(WE3), 64'd0);
    chk("rst_wa3", 64'(WA3), 64'd0);
    chk("rst_wd3", 64'(WD3), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_mem_ready", 64'(mem_ready), 64'd1);
  endtask

  initial begin
    do_reset(2);
    mon_en = 1'b1;

    // ALU only
    drive(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'h0);
    chk("alu_we3", 64'(WE3), 64'd1);
    chk("alu_pending", 64'(pending), 64'd0);

    // Bypass with empty FIFO
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h1234);
    chk("byp_we3", 64'(WE3), 64'd1);
    chk("byp_wa3", 64'(WA3), 64'd6);
    chk("byp_count", 64'(count), 64'd0);

    // Contention: ALU hogs the port while four loads queue up
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'd4, 32'hA000_0000 + 32'(i), 1'b1, 5'(7 + i), 32'hC000_0000 + 32'(i));
    chk("full_count", 64'(count), 64'd4);
    chk("full_mem_ready", 64'(mem_ready), 64'd0);
    chk("full_pending", 64'(pending), 64'h0780);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("drain_we3", 64'(WE3), 64'd1);
      chk("drain_wa3", 64'(WA3), 64'(7 + i));
    end

    // WAW invalidation of a queued load
    drive(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd9, 32'hDEAD_0009);
    chk("waw_pending_set", 64'(pending), 64'h0200);
    drive(1'b1, 5'd9, 32'h0000_BEEF, 1'b0, 5'd0, 32'h0);
    chk("waw_wd3", 64'(WD3), 64'h0000_BEEF);
    chk("waw_pending_clr", 64'(pending), 64'h0);
    idle();
    chk("waw_pop_we3", 64'(WE3), 64'd0);
    chk("waw_pop_wd3", 64'(WD3), 64'h0000_BEEF);
    chk("waw_count", 64'(count), 64'd0);

    // Filtering of illegal destinations from both sources
    drive(1'b1, 5'd0,    32'h1, 1'b1, 5'd15,   32'h2);
    chk("filt_we3_a", 64'(WE3), 64'd0);
    drive(1'b1, 5'h13,   32'h3, 1'b1, 5'h13,   32'h4);
    chk("filt_we3_b", 64'(WE3), 64'd0);
    drive(1'b1, 5'd15,   32'h5, 1'b1, 5'd0,    32'h6);
    chk("filt_we3_c", 64'(WE3), 64'd0);
    chk("filt_count", 64'(count), 64'd0);

    // Reset mid-operation with three queued loads
    for (int i = 0; i < 3; i++)
      drive(1'b1, 5'd4, 32'hB000_0000 + 32'(i), 1'b1, 5'(11 + i), 32'hD000_0000 + 32'(i));
    chk("pre_rst_count", 64'(count), 64'd3);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("post_rst_we3", 64'(WE3), 64'd0);
    end

    // Random mix, biased toward legal and colliding destinations
    for (int c = 0; c < 300; c++) begin
      logic       av, mv;
      logic [4:0] aa, ma;
      av = ($urandom_range(0, 2) != 0);
      mv = ($urandom_range(0, 1) != 0);
      aa = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
      ma = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
      drive(av, aa, $urandom, mv, ma, $urandom);
    end
    repeat (DEPTH + 2) idle();

    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
